// File: rtl/proc_data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// ProcessorMemPkg: shared types and constants for the data-port responder.
// Revision: 1.0
// ============================================================================
package ProcessorMemPkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'h0;
    localparam int          WORD_BYTES   = 4;

endpackage : ProcessorMemPkg
`default_nettype wire

// File: rtl/proc_data_mem_responder_word_ram.sv
`default_nettype none
// ============================================================================
// word_ram: word-addressed array, synchronous write, combinational read.
// Revision: 1.0
// ============================================================================
module word_ram #(
    parameter int MBUS  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [MBUS-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [MBUS-1:0] o_rdata
);

    logic [MBUS-1:0] r_mem [DEPTH];

    // No reset: contents survive a processor reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : word_ram
`default_nettype wire

// File: rtl/proc_data_mem_responder.sv
`default_nettype none
// ============================================================================
// proc_data_mem_responder: fixed-latency data-port memory with stall/valid.
// Revision: 1.0
// ============================================================================
module proc_data_mem_responder
    import ProcessorMemPkg::*;
#(
    parameter int              MBUS       = 32,
    parameter int              DEPTH      = 1024,
    parameter logic [MBUS-1:0] BASE_ADDR  = '0,
    parameter int              RD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MRE,
    input  logic            MWE,
    input  logic [MBUS-1:0] addressData,
    input  logic [MBUS-1:0] storeData,
    output logic [MBUS-1:0] loadedData,
    output logic            stall,
    output logic            rdValid,
    output logic            addrErr
);

    localparam int              c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MBUS:0]   c_BASE   = {1'b0, BASE_ADDR};
    localparam logic [MBUS:0]   c_SPAN   = (MBUS+1)'(WORD_BYTES * DEPTH);
    localparam logic [3:0]      c_LAT_M1 = 4'(RD_LATENCY - 1);
    localparam logic [MBUS-1:0] c_ERR    = MBUS'(MEM_ERR_DATA);

    mem_state_e        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [c_AW-1:0]   r_idx, w_idx_nxt;
    logic              r_vld, w_vld_nxt;
    logic [MBUS-1:0]   r_loaded, w_loaded_nxt;
    logic              r_addr_err, w_err_nxt;

    logic [MBUS:0]     w_offset;
    logic [c_AW-1:0]   w_index;
    logic              w_req_ok;
    logic              w_we;
    logic              w_stall;
    logic              w_rd_valid;
    logic [c_AW-1:0]   w_raddr;
    logic [MBUS-1:0]   w_rdata;

    // One extra bit so an address below BASE_ADDR wraps to a huge offset.
    assign w_offset = {1'b0, addressData} - c_BASE;
    assign w_index  = w_offset[c_AW+1:2];
    assign w_req_ok = (addressData[1:0] == 2'b00) && (w_offset < c_SPAN);

    // In IDLE the live index feeds the RAM so a 1-cycle read can complete.
    assign w_raddr = (r_state == MEM_IDLE) ? w_index : r_idx;

    word_ram #(
        .MBUS  (MBUS),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_wdata (storeData),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= MEM_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_vld      <= 1'b0;
            r_loaded   <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_vld      <= w_vld_nxt;
            r_loaded   <= w_loaded_nxt;
            r_addr_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_vld_nxt    = r_vld;
        w_loaded_nxt = r_loaded;
        w_err_nxt    = 1'b0;
        w_we         = 1'b0;
        w_stall      = 1'b0;
        w_rd_valid   = 1'b0;

        case (r_state)
            MEM_IDLE: begin
                if (MWE) begin
                    // A write wins over a simultaneous read.
                    w_we      = w_req_ok;
                    w_err_nxt = !w_req_ok;
                end else if (MRE) begin
                    w_stall   = 1'b1;
                    w_err_nxt = !w_req_ok;
                    w_idx_nxt = w_index;
                    w_vld_nxt = w_req_ok;
                    w_cnt_nxt = c_LAT_M1;
                    if (RD_LATENCY == 1) begin
                        w_state_nxt  = MEM_RESP;
                        w_loaded_nxt = w_req_ok ? w_rdata : c_ERR;
                    end else begin
                        w_state_nxt  = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt  = MEM_RESP;
                    w_loaded_nxt = r_vld ? w_rdata : c_ERR;
                end
            end
            MEM_RESP: begin
                w_rd_valid  = 1'b1;
                w_state_nxt = MEM_IDLE;
            end
            default: begin
                w_state_nxt = MEM_IDLE;
            end
        endcase
    end

    assign loadedData = r_loaded;
    assign stall      = w_stall;
    assign rdValid    = w_rd_valid;
    assign addrErr    = r_addr_err;

endmodule : proc_data_mem_responder
`default_nettype wire
